countdown_seq_ctrl: RTL and testbench
=====================================

Name: countdown_seq_ctrl

Overview:
Synchronous sequencer for the team's down-count datapath.
- Loads a programmable start value and decrements it to zero under start/stop/pause control.
- Flags terminal count with a one-cycle done pulse and optionally auto-reloads for periodic operation.
- Sits between the control logic and any down-counter consumer, replacing free-running ripple counting with a controlled, single-clock timer.

Parameters:
WIDTH, 4, counter width in bits (min 2)
PRESCALE, 4, clock cycles per decrement when the prescaler option is compiled in (min 2)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin count from load_val; sampled in IDLE and DONE only
stop  input  1  abort count, return to IDLE
pause  input  1  level: hold count while high (RUN/PAUSED only)
reload  input  1  level: auto-reload at terminal count instead of stopping
load_val  input  WIDTH  start value, sampled on start and on auto-reload
q  output  WIDTH  current count
busy  output  1  high in RUN or PAUSED
done  output  1  registered one-cycle pulse at terminal count
state  output  2  FSM state: IDLE=00, RUN=01, PAUSED=10, DONE=11

Behaviour:
- Reset (rst low, asynchronous):
  - q = all ones; state = IDLE; busy = 0; done = 0; prescaler = 0.
  - Release is synchronous to the next clk edge.
- tick: 1 every RUN cycle (option off), or once per PRESCALE RUN cycles (option on).
- Command priority every cycle: stop > start > pause > tick.
- IDLE:
  - q holds.
  - start=1 and load_val!=0: q<=load_val, prescaler<=0, next state RUN.
  - start=1 and load_val==0: q<=0, done pulses next cycle, next state DONE.
  - start and stop together: stay IDLE, q unchanged.
- RUN:
  - stop: next state IDLE, q holds current value, no done.
  - pause (no stop): next state PAUSED, q and prescaler hold.
  - tick with q>1: q<=q-1.
  - tick with q==1 (terminal): done<=1 for exactly one cycle, then
    - reload=1: q<=load_val (sampled this edge), stay RUN; if that load_val==0, q<=0 and next state DONE.
    - reload=0: q<=0, next state DONE.
  - start ignored.
- PAUSED:
  - q and prescaler frozen.
  - pause=0: back to RUN, resuming exactly where it left off.
  - stop: IDLE.
  - start ignored.
- DONE:
  - q=0 held; busy=0.
  - start: same action as from IDLE.
  - stop: IDLE.
- Latency (option off):
  - start sampled at edge k, so q=load_val after k.
  - First decrement at edge k+1.
  - Terminal reached N edges after k for load_val=N; done is high during the cycle after that edge.
- Period with reload, option off: N cycles per done pulse. load_val=1 gives done high continuously.
- Arithmetic: unsigned WIDTH-bit. q never wraps below 0; the 0-to-all-ones transition is impossible in RUN.
- busy is combinational from state; done and q are registered.
- Reset asserted mid-count: immediate return to reset values, no done pulse.

Optional Feature:
Macro COUNTDOWN_PRESCALE_EN.
- Defined:
  - A prescaler counter of width clog2(PRESCALE) advances only in RUN.
  - tick fires when the prescaler reaches PRESCALE-1, after which it wraps to 0.
  - The prescaler clears on start and on auto-reload, and is held in PAUSED.
  - load_val=N gives done after N*PRESCALE RUN cycles.
- Undefined:
  - No prescaler logic; tick=1 every RUN cycle; PRESCALE is ignored.

Test Plan:
1. Reset and basic count (option off): hold rst=0 for 3 cycles -> q=4'hF, state=00, busy=0, done=0. Release, start=1 for 1 cycle with load_val=5 -> q sequence 5,4,3,2,1,0; done high for exactly 1 cycle when q=0; state=11; busy falls.
2. Pause and stop: load_val=9, start. At q=6 raise pause for 4 cycles -> q stays 6, state=10. Release -> count resumes at 5. At q=3 pulse stop -> state=00, q stays 3, no done.
3. Auto-reload: reload=1, load_val=3, start -> q 3,2,1,3,2,1,... with done every 3 cycles. Drop reload before terminal -> next terminal goes to q=0, state DONE.
4. Boundaries:
   - start with load_val=0 -> DONE, q=0, single done pulse.
   - start and stop in the same cycle from IDLE -> stays IDLE.
   - start while RUN -> ignored, count continues.
5. Async reset mid-count: assert rst between clock edges at q=4 -> q=4'hF and state=00 immediately, without waiting for a clock edge; no done pulse.
6. COUNTDOWN_PRESCALE_EN defined, PRESCALE=4, load_val=2: start -> q changes every 4 cycles; done after 8 RUN cycles. A 3-cycle pause mid-interval extends total time by exactly 3 cycles.

Source files
------------

// File: rtl/countdown_seq_ctrl.sv
// countdown_seq_ctrl: start/stop/pause controlled down-counter sequencer.
// Loads a programmable start value and counts it down to zero.
// It raises a one-cycle done pulse at terminal count.
// It can auto-reload at terminal count for periodic operation.
// Optional feature macro: COUNTDOWN_PRESCALE_EN. When it is defined, the
// counter steps once every PRESCALE run cycles instead of every run cycle.
// State encoding seen on the state output:
//   IDLE=00, RUN=01, PAUSED=10, DONE=11.
module countdown_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2) begin : g_width_chk
    $error("countdown_seq_ctrl: WIDTH must be at least 2");
  end
  if (PRESCALE < 2) begin : g_prescale_chk
    $error("countdown_seq_ctrl: PRESCALE must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             done_q;

  logic             active_s;    // counting may advance this cycle
  logic             tick_s;      // counter steps this cycle
  logic             at_one_s;    // count is at terminal value 1
  logic             at_zero_s;   // count is zero (defensive, never in RUN)
  logic             load_zero_s; // requested load value is zero

  assign at_one_s    = (cnt_q == WIDTH'(1));
  assign at_zero_s   = (cnt_q == {WIDTH{1'b0}});
  assign load_zero_s = (load_val == {WIDTH{1'b0}});

  // Pause is a level hold in RUN or PAUSED.
  // Leaving PAUSED resumes on the same edge, so a pause held for n cycles
  // costs exactly n cycles of count time.
  always_comb begin
    active_s = 1'b0;
    if (((state_q == ST_RUN) || (state_q == ST_PAUSED)) && !stop && !pause) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
  end

`ifdef COUNTDOWN_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q;
  logic          presc_last_s;
  logic          start_take_s;

  assign presc_last_s = (presc_q == PW'(PRESCALE - 1));

  // Start is accepted only from IDLE or DONE, and only when stop is low.
  always_comb begin
    start_take_s = 1'b0;
    if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !stop) begin
      start_take_s = 1'b1;
    end else begin
      start_take_s = 1'b0;
    end
  end

  // The counter only steps on the last prescaler phase of an active cycle.
  always_comb begin
    tick_s = 1'b0;
    if (active_s && presc_last_s) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescaler behaviour:
  //  - advances only while active;
  //  - wraps after PRESCALE-1;
  //  - clears when a start is taken.
  // Auto-reload happens on a tick, so the wrap already clears it then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= {PW{1'b0}};
    end else if (start_take_s) begin
      presc_q <= {PW{1'b0}};
    end else if (active_s) begin
      if (presc_last_s) begin
        presc_q <= {PW{1'b0}};
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end else begin
      presc_q <= presc_q;
    end
  end
`else
  // Without the prescaler every active cycle is a tick.
  always_comb begin
    tick_s = 1'b0;
    if (active_s) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end
`endif

  // Main sequencer: state, count and the registered done pulse.
  // Command priority is stop > start > pause > tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {WIDTH{1'b1}};
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (start) begin
            if (load_zero_s) begin
              cnt_q   <= {WIDTH{1'b0}};
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q   <= load_val;
              state_q <= ST_RUN;
            end
          end else begin
            state_q <= state_q;
          end
        end
        ST_RUN, ST_PAUSED: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (pause) begin
            state_q <= ST_PAUSED;
          end else if (tick_s) begin
            if (at_one_s) begin
              done_q <= 1'b1;
              if (reload && !load_zero_s) begin
                cnt_q   <= load_val;
                state_q <= ST_RUN;
              end else begin
                cnt_q   <= {WIDTH{1'b0}};
                state_q <= ST_DONE;
              end
            end else if (at_zero_s) begin
              // Unreachable in normal use; end the count rather than wrap.
              state_q <= ST_DONE;
            end else begin
              cnt_q   <= cnt_q - WIDTH'(1);
              state_q <= ST_RUN;
            end
          end else begin
            // Prescaler phase without a tick: stay or resume in RUN.
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign q     = cnt_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_countdown_seq_ctrl.sv
// Directed self-checking bench for countdown_seq_ctrl.
// Build with COUNTDOWN_PRESCALE_EN defined to exercise the prescaler.
module tb_countdown_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       reload;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int errors;
  int checks;

  countdown_seq_ctrl #(
    .WIDTH    (4),
    .PRESCALE (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .reload   (reload),
    .load_val (load_val),
    .q        (q),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    reload   = 1'b0;
    load_val = 4'd0;

    // Reset values
    repeat (3) step();
    check("rst_q", 32'(q), 32'hF);
    check("rst_state", 32'(state), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b1;
    step();
    check("idle_hold_q", 32'(q), 32'hF);

`ifdef COUNTDOWN_PRESCALE_EN
    // Prescaled count: load 2, one step every 4 cycles, done after 8
    start = 1'b1; load_val = 4'd2;
    step();
    start = 1'b0;
    check("ps_load_q", 32'(q), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("ps_q", 32'(q), (i < 4) ? 32'd2 : ((i < 8) ? 32'd1 : 32'd0));
      check("ps_done", 32'(done), (i == 8) ? 32'd1 : 32'd0);
    end
    check("ps_state_done", 32'(state), 32'h3);

    // Three-cycle pause mid-interval moves done from 8 to 11
    start = 1'b1; load_val = 4'd2;
    step();
    start = 1'b0;
    check("psp_load_q", 32'(q), 32'd2);
    begin
      int adv;
      adv = 0;
      for (int i = 1; i <= 11; i++) begin
        pause = (i >= 3 && i <= 5) ? 1'b1 : 1'b0;
        step();
        if (!pause) adv++;
        check("psp_q", 32'(q), (adv < 4) ? 32'd2 : ((adv < 8) ? 32'd1 : 32'd0));
        check("psp_done", 32'(done), (i == 11) ? 32'd1 : 32'd0);
        if (pause) check("psp_state", 32'(state), 32'h2);
      end
      pause = 1'b0;
    end
`else
    // Test 1: basic count from 5
    start = 1'b1; load_val = 4'd5;
    step();
    start = 1'b0;
    check("t1_q5", 32'(q), 32'd5);
    check("t1_state_run", 32'(state), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_done0", 32'(done), 32'h0);
    for (int v = 4; v >= 1; v--) begin
      step();
      check("t1_q", 32'(q), 32'(v));
      check("t1_nodone", 32'(done), 32'h0);
    end
    step();
    check("t1_q0", 32'(q), 32'd0);
    check("t1_done", 32'(done), 32'h1);
    check("t1_state_done", 32'(state), 32'h3);
    check("t1_busy_fall", 32'(busy), 32'h0);
    step();
    check("t1_done_once", 32'(done), 32'h0);
    check("t1_q0_hold", 32'(q), 32'd0);

    // Test 2: pause at 6 for 4 cycles, stop at 3
    start = 1'b1; load_val = 4'd9;
    step();
    start = 1'b0;
    check("t2_q9", 32'(q), 32'd9);
    for (int v = 8; v >= 6; v--) begin
      step();
      check("t2_q", 32'(q), 32'(v));
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_pause_q", 32'(q), 32'd6);
      check("t2_pause_state", 32'(state), 32'h2);
      check("t2_pause_busy", 32'(busy), 32'h1);
    end
    pause = 1'b0;
    step();
    check("t2_resume_q", 32'(q), 32'd5);
    check("t2_resume_state", 32'(state), 32'h1);
    step();
    step();
    check("t2_q3", 32'(q), 32'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t2_stop_state", 32'(state), 32'h0);
    check("t2_stop_q", 32'(q), 32'd3);
    check("t2_stop_done", 32'(done), 32'h0);
    step();
    check("t2_idle_q", 32'(q), 32'd3);

    // Test 3: auto-reload with load 3, then drop reload
    reload = 1'b1; start = 1'b1; load_val = 4'd3;
    step();
    start = 1'b0;
    check("t3_q3", 32'(q), 32'd3);
    begin
      logic [3:0] exp_q [7];
      logic       exp_d [7];
      exp_q = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
      exp_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
        step();
        check("t3_q", 32'(q), 32'(exp_q[i]));
        check("t3_done", 32'(done), 32'(exp_d[i]));
        check("t3_state", 32'(state), 32'h1);
      end
    end
    reload = 1'b0;
    step();
    check("t3_q1", 32'(q), 32'd1);
    step();
    check("t3_end_q", 32'(q), 32'd0);
    check("t3_end_done", 32'(done), 32'h1);
    check("t3_end_state", 32'(state), 32'h3);

    // Test 4a: start with load 0 from DONE
    start = 1'b1; load_val = 4'd0;
    step();
    start = 1'b0;
    check("t4_zero_q", 32'(q), 32'd0);
    check("t4_zero_state", 32'(state), 32'h3);
    check("t4_zero_done", 32'(done), 32'h1);
    step();
    check("t4_zero_done_once", 32'(done), 32'h0);
    // Test 4b: stop from DONE, then start+stop from IDLE
    stop = 1'b1;
    step();
    check("t4_stop_idle", 32'(state), 32'h0);
    start = 1'b1; load_val = 4'd7;
    step();
    check("t4_ss_state", 32'(state), 32'h0);
    check("t4_ss_q", 32'(q), 32'd0);
    check("t4_ss_done", 32'(done), 32'h0);
    // Test 4c: start while RUN is ignored
    stop = 1'b0;
    step();
    check("t4_run_q7", 32'(q), 32'd7);
    load_val = 4'd2;
    step();
    check("t4_ign_q", 32'(q), 32'd6);
    check("t4_ign_state", 32'(state), 32'h1);
    start = 1'b0;
    step();
    check("t4_q5", 32'(q), 32'd5);
    step();
    check("t5_pre_q4", 32'(q), 32'd4);

    // Test 5: async reset between edges
    #3;
    rst = 1'b0;
    #1;
    check("t5_async_q", 32'(q), 32'hF);
    check("t5_async_state", 32'(state), 32'h0);
    check("t5_async_busy", 32'(busy), 32'h0);
    check("t5_async_done", 32'(done), 32'h0);
    step();
    check("t5_hold_done", 32'(done), 32'h0);
    rst = 1'b1;
    step();
    check("t5_rel_q", 32'(q), 32'hF);

    // Reload with load 1: done stays high every cycle
    reload = 1'b1; start = 1'b1; load_val = 4'd1;
    step();
    start = 1'b0;
    check("r1_q", 32'(q), 32'd1);
    check("r1_done0", 32'(done), 32'h0);
    step();
    check("r1_done_a", 32'(done), 32'h1);
    check("r1_q_a", 32'(q), 32'd1);
    step();
    check("r1_done_b", 32'(done), 32'h1);
    reload = 1'b0;
    step();
    check("r1_end_q", 32'(q), 32'd0);
    check("r1_end_done", 32'(done), 32'h1);
    check("r1_end_state", 32'(state), 32'h3);
    step();
    check("r1_end_done_once", 32'(done), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
